// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter: round-robin grant of one register-file write port among
// NUM_REQ requesters, plus a per-register pending-write scoreboard for issue.
module reg_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      wr_enable,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  input  logic                      claim_valid,
  input  logic [ADDR_W-1:0]         claim_addr,
  output logic                      claim_stall,
  input  logic [ADDR_W-1:0]         hz_addr1,
  input  logic [ADDR_W-1:0]         hz_addr2,
  output logic                      hz_busy1,
  output logic                      hz_busy2,
  input  logic                      flush,
  output logic [31:0]               busy_mask
);

  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  logic [1:0]         rr_ptr_reg, rr_ptr_next;
  logic [NUM_REQ-1:0] grant;
  logic               found;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               xfer;
  logic               do_write;
  logic               do_claim;

  logic               wr_enable_reg;
  logic [ADDR_W-1:0]  wr_addr_reg;
  logic [DATA_W-1:0]  wr_data_reg;
  logic [31:0]        busy_reg, busy_next;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Walk requesters starting at rr_ptr; only the granted slot's addr/data
  // reach the mux, so idle requesters cannot leak X into the write port.
  always_comb begin
    grant       = '0;
    found       = 1'b0;
    sel_addr    = '0;
    sel_data    = '0;
    rr_ptr_next = rr_ptr_reg;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && ((int'(rr_ptr_reg) + k) % NUM_REQ) == j && req_valid[j]) begin
          found       = 1'b1;
          grant[j]    = 1'b1;
          sel_addr    = addr_arr[j];
          sel_data    = data_arr[j];
          rr_ptr_next = 2'((j + 1) % NUM_REQ);
        end
      end
    end
  end

  assign req_ready = rst ? grant : '0;
  assign xfer      = rst & found;
  assign do_write  = xfer && (sel_addr != '0);

  assign claim_stall = claim_valid & busy_reg[claim_addr];
  assign do_claim    = claim_valid && (claim_addr != '0) && !claim_stall;
  assign hz_busy1    = busy_reg[hz_addr1];
  assign hz_busy2    = busy_reg[hz_addr2];

  // Release and claim never hit the same register while it is pending
  // (the claim stalls); flush wins over both.
  always_comb begin
    busy_next = busy_reg;
    if (do_write) busy_next[sel_addr] = 1'b0;
    if (do_claim) busy_next[claim_addr] = 1'b1;
    if (flush) busy_next = '0;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_reg    <= '0;
      wr_enable_reg <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      busy_reg      <= '0;
    end else begin
      rr_ptr_reg    <= rr_ptr_next;
      wr_enable_reg <= do_write;
      if (do_write) begin
        wr_addr_reg <= sel_addr;
        wr_data_reg <= sel_data;
      end
      busy_reg <= busy_next;
    end
  end

  assign wr_enable = wr_enable_reg;
  assign wr_addr   = wr_addr_reg;
  assign wr_data   = wr_data_reg;
  assign busy_mask = busy_reg;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed scenarios with literal expectations, then
// random traffic checked every cycle against a behavioural model.
module tb_reg_wb_arbiter;
  localparam int N  = 3;
  localparam int DW = 64;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic            wr_enable;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            claim_valid, claim_stall;
  logic [AW-1:0]   claim_addr, hz_addr1, hz_addr2;
  logic            hz_busy1, hz_busy2, flush;
  logic [31:0]     busy_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_valid(claim_valid), .claim_addr(claim_addr), .claim_stall(claim_stall),
    .hz_addr1(hz_addr1), .hz_addr2(hz_addr2),
    .hz_busy1(hz_busy1), .hz_busy2(hz_busy2),
    .flush(flush), .busy_mask(busy_mask)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_addr[i*AW +: AW]  = a;
    req_data[i*DW +: DW]  = d;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: pointer as an integer, pending set as a 32-bit mask,
  // last issued write. Checked at every falling edge, then advanced to the
  // state the next rising edge must produce.
  int             m_rr;
  logic [31:0]    m_busy;
  logic           m_wen;
  logic [AW-1:0]  m_waddr;
  logic [DW-1:0]  m_wdata;
  int             g, idx;
  logic [N-1:0]   er;
  logic           es;
  logic [AW-1:0]  a;

  always @(negedge clk) begin
    if (!rst) begin
      m_rr = 0; m_busy = '0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
      chk("m_rst_ready", 64'(req_ready), 64'd0);
      chk("m_rst_wen", 64'(wr_enable), 64'd0);
      chk("m_rst_busy", 64'(busy_mask), 64'd0);
    end else begin
      g  = -1;
      er = '0;
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (g < 0 && req_valid[idx]) begin
          g       = idx;
          er[idx] = 1'b1;
        end
      end
      es = claim_valid && (claim_addr != 0) && m_busy[claim_addr];
      chk("m_ready", 64'(req_ready), 64'(er));
      chk("m_stall", 64'(claim_stall), 64'(es));
      chk("m_hz1", 64'(hz_busy1), 64'((hz_addr1 != 0) && m_busy[hz_addr1]));
      chk("m_hz2", 64'(hz_busy2), 64'((hz_addr2 != 0) && m_busy[hz_addr2]));
      chk("m_busy", 64'(busy_mask), 64'(m_busy));
      chk("m_wen", 64'(wr_enable), 64'(m_wen));
      if (m_wen) begin
        chk("m_waddr", 64'(wr_addr), 64'(m_waddr));
        chk("m_wdata", wr_data, m_wdata);
      end
      m_wen = 1'b0;
      if (g >= 0) begin
        m_rr = (g + 1) % N;
        a    = req_addr[g*AW +: AW];
        if (a != 0) begin
          m_wen     = 1'b1;
          m_waddr   = a;
          m_wdata   = req_data[g*DW +: DW];
          m_busy[a] = 1'b0;
        end
      end
      if (claim_valid && claim_addr != 0 && !es) m_busy[claim_addr] = 1'b1;
      if (flush) m_busy = '0;
    end
  end

  logic [N-1:0] fired;

  initial begin
    req_valid = '0; req_addr = '0; req_data = '0;
    claim_valid = 1'b0; claim_addr = '0; hz_addr1 = '0; hz_addr2 = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_waddr", 64'(wr_addr), 64'd0);
    chk("reset_wdata", wr_data, 64'd0);
    rst = 1'b1;

    // Round-robin with all three requesters valid
    set_req(0, 1'b1, 5'd5, 64'h100);
    set_req(1, 1'b1, 5'd6, 64'h101);
    set_req(2, 1'b1, 5'd7, 64'h102);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k < 6) chk("rr_grant", 64'(req_ready), 64'd1 << (k % 3));
      else       chk("rr_idle", 64'(req_ready), 64'd0);
      if (k > 0) begin
        chk("rr_wen", 64'(wr_enable), 64'd1);
        chk("rr_waddr", 64'(wr_addr), 64'(5 + ((k - 1) % 3)));
      end
      step();
      if (k == 5) req_valid = '0;
    end

    // Single requester 2
    set_req(2, 1'b1, 5'd9, 64'hDEAD_BEEF);
    @(negedge clk); chk("single_ready", 64'(req_ready), 64'b100);
    step(); req_valid = '0;
    @(negedge clk);
    chk("single_wen", 64'(wr_enable), 64'd1);
    chk("single_waddr", 64'(wr_addr), 64'd9);
    chk("single_wdata", wr_data, 64'hDEAD_BEEF);
    step();
    @(negedge clk); chk("single_wen_off", 64'(wr_enable), 64'd0);
    step();

    // Scoreboard claim / stall / release
    claim_valid = 1'b1; claim_addr = 5'd12; hz_addr1 = 5'd12;
    @(negedge clk); chk("claim_nostall", 64'(claim_stall), 64'd0);
    step(); claim_valid = 1'b0;
    @(negedge clk);
    chk("claim_busy", 64'(busy_mask), 64'h1000);
    chk("claim_hz1", 64'(hz_busy1), 64'd1);
    step(); claim_valid = 1'b1;
    @(negedge clk); chk("reclaim_stall", 64'(claim_stall), 64'd1);
    step(); claim_valid = 1'b0;
    @(negedge clk); chk("reclaim_nochange", 64'(busy_mask), 64'h1000);
    step();
    set_req(0, 1'b1, 5'd12, 64'h12);
    @(negedge clk); chk("release_ready", 64'(req_ready), 64'b001);
    step(); req_valid = '0;
    @(negedge clk);
    chk("release_busy", 64'(busy_mask), 64'd0);
    chk("release_waddr", 64'(wr_addr), 64'd12);
    step();
    claim_valid = 1'b1; claim_addr = 5'd3;
    step();
    claim_addr = 5'd12; hz_addr2 = 5'd3;
    set_req(1, 1'b1, 5'd3, 64'h3);
    @(negedge clk); chk("both_hz2", 64'(hz_busy2), 64'd1);
    step(); claim_valid = 1'b0; req_valid = '0;
    @(negedge clk);
    chk("both_busy", 64'(busy_mask), 64'h1000);
    chk("both_hz2_clear", 64'(hz_busy2), 64'd0);
    step();

    // x0 handling
    claim_valid = 1'b1; claim_addr = 5'd0; hz_addr1 = 5'd0;
    @(negedge clk);
    chk("x0_stall", 64'(claim_stall), 64'd0);
    chk("x0_hz1", 64'(hz_busy1), 64'd0);
    step(); claim_valid = 1'b0;
    @(negedge clk); chk("x0_busy", 64'(busy_mask), 64'h1000);
    step();
    set_req(2, 1'b1, 5'd0, 64'hAA);
    @(negedge clk); chk("x0_ready", 64'(req_ready), 64'b100);
    step(); req_valid = '0;
    @(negedge clk); chk("x0_wen", 64'(wr_enable), 64'd0);
    step();

    // Flush with concurrent claim and writeback
    set_req(0, 1'b1, 5'd12, 64'h1212);
    step(); req_valid = '0;
    claim_valid = 1'b1; claim_addr = 5'd4;  step();
    claim_addr = 5'd8;  step();
    claim_addr = 5'd20; step();
    claim_valid = 1'b0;
    @(negedge clk); chk("pre_flush_busy", 64'(busy_mask), 64'h100110);
    step();
    flush = 1'b1; claim_valid = 1'b1; claim_addr = 5'd30;
    set_req(0, 1'b1, 5'd8, 64'h8888);
    @(negedge clk); chk("flush_ready", 64'(req_ready), 64'b001);
    step(); flush = 1'b0; claim_valid = 1'b0; req_valid = '0;
    @(negedge clk);
    chk("flush_busy", 64'(busy_mask), 64'd0);
    chk("flush_wen", 64'(wr_enable), 64'd1);
    chk("flush_waddr", 64'(wr_addr), 64'd8);
    chk("flush_wdata", wr_data, 64'h8888);
    step();

    // Asynchronous reset in the middle of a write
    set_req(1, 1'b1, 5'd5, 64'h55);
    claim_valid = 1'b1; claim_addr = 5'd17;
    step(); claim_valid = 1'b0;
    chk("pre_rst_wen", 64'(wr_enable), 64'd1);
    chk("pre_rst_busy", 64'(busy_mask), 64'h20000);
    #2 rst = 1'b0;
    #1;
    chk("arst_wen", 64'(wr_enable), 64'd0);
    chk("arst_waddr", 64'(wr_addr), 64'd0);
    chk("arst_wdata", wr_data, 64'd0);
    chk("arst_busy", 64'(busy_mask), 64'd0);
    chk("arst_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    req_valid = '0;
    #2 rst = 1'b1;
    step();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      fired = req_valid & req_ready;
      step();
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || fired[i]) begin
          if ($urandom_range(0, 2) != 0)
            set_req(i, 1'b1, AW'($urandom_range(0, 31)), {$urandom, $urandom});
          else
            set_req(i, 1'b0, '0, '0);
        end
      end
      flush       = ($urandom_range(0, 29) == 0);
      claim_valid = 1'($urandom_range(0, 1));
      claim_addr  = AW'($urandom_range(0, 31));
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_addr[i*AW +: AW] == claim_addr) claim_valid = 1'b0;
      hz_addr1 = AW'($urandom_range(0, 31));
      hz_addr2 = AW'($urandom_range(0, 31));
    end
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Owns the single write port of the 32x64 integer register file.
- Arbitrates round-robin between NUM_REQ writeback requesters (ALU, load unit, CSR/mul) using a valid/ready handshake, with one-cycle registered latency to the port.
- Keeps a per-register pending-write scoreboard. Issue logic claims a destination and queries operand hazards against it.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..4)
DATA_W, 64, register data width
ADDR_W, 5, register address width (32 registers)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  NUM_REQ  requester i holds a write
req_ready  output  NUM_REQ  requester i granted this cycle
req_addr  input  NUM_REQ*ADDR_W  destination per requester, slice i at [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*DATA_W  write data per requester, slice i at [i*DATA_W +: DATA_W]
wr_enable  output  1  register-file write enable
wr_addr  output  ADDR_W  register-file write address
wr_data  output  DATA_W  register-file write data
claim_valid  input  1  issue stage reserves destination claim_addr
claim_addr  input  ADDR_W  destination being reserved
claim_stall  output  1  claim refused, destination already pending
hz_addr1  input  ADDR_W  source operand 1 to check
hz_addr2  input  ADDR_W  source operand 2 to check
hz_busy1  output  1  operand 1 has a pending write
hz_busy2  output  1  operand 2 has a pending write
flush  input  1  discard all reservations (pipeline flush)
busy_mask  output  32  scoreboard state, bit r = register r pending

Behaviour:
Reset (rst low, async):
- wr_enable=0, wr_addr=0, wr_data=0, busy_mask=0, rr_ptr=0.
- req_ready=0 while rst low.
- Deassertion takes effect at the next rising edge.

Arbitration:
- rr_ptr is a 2-bit register.
- Search order: rr_ptr, rr_ptr+1, ... mod NUM_REQ. Grant the first index with req_valid set.
- req_ready is combinational and one-hot (or zero). At most one grant per cycle.
- A transfer happens when req_valid[i] & req_ready[i].
- Requester holds valid, addr and data stable until the transfer. Valid must not drop before ready.
- After a grant to i: rr_ptr <= (i+1) mod NUM_REQ. With no grant, rr_ptr is unchanged.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles.

Write port:
- A transfer at edge N registers wr_addr/wr_data and drives wr_enable=1 for the cycle after N. Latency is exactly 1 cycle.
- With no transfer, wr_enable=0 and wr_addr/wr_data hold their last values.
- A transfer with addr 0 is accepted (ready=1), but wr_enable stays 0. The write is dropped and the scoreboard is untouched.

Scoreboard:
- Claim: at an edge with claim_valid=1, claim_addr!=0 and claim_stall=0, set busy_mask[claim_addr].
- claim_stall = claim_valid & busy_mask[claim_addr], combinational. A stalled claim has no effect; issue must retry.
- Release: a transfer to addr r (r!=0) clears busy_mask[r] at the same edge that registers the write.
- Claim and release of the same register at the same edge cannot occur, because the claim stalls. Claim and release of different registers at the same edge both take effect.
- hz_busyN = busy_mask[hz_addrN], combinational from registered state. No bypass of same-cycle release.
- bit 0 is constant 0. Claims or queries of x0 never stall or report busy.
- flush=1 clears all busy_mask bits at the edge, overriding claim and release at that edge.
- flush does not affect arbitration, rr_ptr or the write port. A transfer in that cycle still writes the register file.

Unused requester slots above NUM_REQ do not exist. No X propagation from invalid requesters' addr/data.

Test Plan:
1. Reset mid-write: rst low while wr_enable=1 -> wr_enable, wr_addr, wr_data, busy_mask and req_ready all 0 immediately, before the clock edge.
2. Round-robin: all three requesters valid continuously with addrs 5/6/7 -> grants 0,1,2,0,1,2. The wr_addr sequence is 5,6,7,5,... one cycle after each grant, and wr_enable stays high every cycle.
3. Single requester: req 2 valid with addr 9, data 0xDEAD_BEEF -> req_ready[2]=1 in the same cycle. Next cycle wr_enable=1, wr_addr=9, wr_data=0xDEAD_BEEF. Following cycle wr_enable=0.
4. Scoreboard:
   - Claim r12 -> busy_mask[12]=1; hz_addr1=12 gives hz_busy1=1.
   - A second claim of r12 gives claim_stall=1 and no change.
   - A writeback to r12 clears the bit at its transfer edge.
   - Claim r12 and writeback r3 at the same edge -> bit12 set, bit3 cleared.
5. x0 handling: claim r0 -> no stall, busy_mask unchanged. Writeback to r0 -> ready=1, wr_enable stays 0.
6. Flush: bits 4, 8 and 20 busy; flush concurrent with claim r30 and writeback r8 -> busy_mask=0. The r8 write is still issued next cycle with wr_enable=1.
